brp_update_sched: RTL and testbench

BRP_UPDATE_SCHED -- requirements
Module: brp_update_sched

---
 rtl/brp_update_sched_pkg.sv | 26 ++
 rtl/brp_update_sched_if.sv | 13 +
 rtl/brp_update_sched_fifo.sv | 51 +++++
 rtl/brp_update_sched.sv | 144 ++++++++++++++
 tb/tb_brp_update_sched.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/brp_update_sched_pkg.sv
// Shared types for the bimodal predictor update scheduler: queued update record,
// scheduler states and the 2-bit saturating counter rule.
package rv32i_types;

    localparam int BRP_PHT_IDX_W = 6;

    typedef struct packed {
        logic [BRP_PHT_IDX_W-1:0] idx;
        logic                     taken;
    } brp_update_t;

    typedef enum logic [1:0] {
        SCHED_INIT,
        SCHED_IDLE,
        SCHED_RD,
        SCHED_WR
    } brp_sched_state_e;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/brp_update_sched_if.sv
// Single-port PHT access bundle; the scheduler is master, the counter RAM is slave.
interface brp_update_sched_if #(
    parameter int IDX_W = rv32i_types::BRP_PHT_IDX_W
);
    logic             pht_en;
    logic             pht_we;
    logic [IDX_W-1:0] pht_addr;
    logic [1:0]       pht_wdata;
    logic [1:0]       pht_rdata;

    modport master (output pht_en, pht_we, pht_addr, pht_wdata, input pht_rdata);
    modport slave  (input pht_en, pht_we, pht_addr, pht_wdata, output pht_rdata);
endinterface

// File: rtl/brp_update_sched_fifo.sv
// In-order queue of resolved branches awaiting a read-modify-write of the PHT.
module brp_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/brp_update_sched.sv
// Arbitrates the single-port PHT between IF lookups (always first) and queued
// counter updates from EX, after an initial sweep that sets every counter to 01.
module brp_update_sched
    import rv32i_types::*;
#(
    parameter int PHT_IDX_W  = BRP_PHT_IDX_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_req,
    input  logic [31:0]          lookup_pc,
    output logic                 lookup_grant,
    output logic                 pred_valid,
    output logic                 pred_taken,
    input  logic                 res_valid,
    input  logic [31:0]          res_pc,
    input  logic                 res_taken,
    input  logic                 res_prediction,
    output logic                 res_ready,
    brp_update_sched_if.master   pht,
    output logic                 init_done,
    output logic [31:0]          c_total,
    output logic [31:0]          c_correct
);
    brp_sched_state_e       state, state_n;
    logic [PHT_IDX_W-1:0]   sweep_idx;
    logic [1:0]             ctr_q;
    logic [PHT_IDX_W-1:0]   lookup_idx;
    logic [PHT_IDX_W-1:0]   res_idx;
    logic [PHT_IDX_W:0]     head;
    logic [PHT_IDX_W-1:0]   head_idx;
    logic                   head_taken;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    logic                   unused_pc_bits;

    assign lookup_idx     = lookup_pc[PHT_IDX_W+1:2];
    assign res_idx        = res_pc[PHT_IDX_W+1:2];
    assign unused_pc_bits = ^{lookup_pc[31:PHT_IDX_W+2], lookup_pc[1:0],
                              res_pc[31:PHT_IDX_W+2], res_pc[1:0]};
    assign head_idx       = head[PHT_IDX_W:1];
    assign head_taken     = head[0];

    assign init_done  = (state != SCHED_INIT);
    assign res_ready  = (state != SCHED_INIT) && !fifo_full;
    assign push       = res_valid && res_ready;
    assign pred_taken = pred_valid & pht.pht_rdata[1];

    brp_fifo #(
        .WIDTH (PHT_IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({res_idx, res_taken}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SCHED_INIT;
            sweep_idx  <= '0;
            ctr_q      <= 2'b00;
            pred_valid <= 1'b0;
            c_total    <= '0;
            c_correct  <= '0;
        end else begin
            state      <= state_n;
            pred_valid <= lookup_grant;
            if (state == SCHED_INIT) begin
                sweep_idx <= sweep_idx + 1'b1;
            end
            if (state == SCHED_RD) begin
                ctr_q <= pht.pht_rdata;
            end
            if (push) begin
                c_total <= c_total + 32'd1;
                if (res_prediction == res_taken) begin
                    c_correct <= c_correct + 32'd1;
                end
            end
        end
    end

    // The update path only owns the port when no lookup wants it; a lookup
    // overrides whatever the update state would have driven this cycle.
    always_comb begin
        state_n       = state;
        lookup_grant  = 1'b0;
        pop           = 1'b0;
        pht.pht_en    = 1'b0;
        pht.pht_we    = 1'b0;
        pht.pht_addr  = '0;
        pht.pht_wdata = 2'b00;
        case (state)
            SCHED_INIT: begin
                pht.pht_en    = 1'b1;
                pht.pht_we    = 1'b1;
                pht.pht_addr  = sweep_idx;
                pht.pht_wdata = 2'b01;
                if (sweep_idx == '1) begin
                    state_n = SCHED_IDLE;
                end
            end
            SCHED_IDLE: begin
                if (!lookup_req && !fifo_empty) begin
                    pht.pht_en   = 1'b1;
                    pht.pht_addr = head_idx;
                    state_n      = SCHED_RD;
                end
            end
            SCHED_RD: begin
                state_n = SCHED_WR;
            end
            SCHED_WR: begin
                if (!lookup_req) begin
                    pht.pht_en    = 1'b1;
                    pht.pht_we    = 1'b1;
                    pht.pht_addr  = head_idx;
                    pht.pht_wdata = ctr_update(ctr_q, head_taken);
                    pop           = 1'b1;
                    state_n       = SCHED_IDLE;
                end
            end
            default: begin
                state_n = SCHED_INIT;
            end
        endcase
        if (state != SCHED_INIT && lookup_req) begin
            lookup_grant  = 1'b1;
            pht.pht_en    = 1'b1;
            pht.pht_we    = 1'b0;
            pht.pht_addr  = lookup_idx;
            pht.pht_wdata = 2'b00;
        end
    end
endmodule

// File: tb/tb_brp_update_sched.sv
// Bench for brp_update_sched: models the PHT RAM and predicts counter contents,
// statistics and port timing from the branch resolutions it issues.
module tb_brp_update_sched;
    localparam int IDX_W = 6;
    localparam int N_ENT = 1 << IDX_W;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_req;
    logic [31:0] lookup_pc;
    logic        lookup_grant;
    logic        pred_valid;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        res_prediction;
    logic        res_ready;
    logic        init_done;
    logic [31:0] c_total;
    logic [31:0] c_correct;

    int checks   = 0;
    int failures = 0;

    logic [1:0]       mem [N_ENT];
    logic [IDX_W-1:0] last_wr_addr;
    logic [1:0]       last_wr_data;
    int               wr_count = 0;

    int ref_ctr [N_ENT];
    int exp_total;
    int exp_correct;

    brp_update_sched_if #(.IDX_W(IDX_W)) pht_bus();

    brp_update_sched #(
        .PHT_IDX_W  (IDX_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_req     (lookup_req),
        .lookup_pc      (lookup_pc),
        .lookup_grant   (lookup_grant),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_prediction (res_prediction),
        .res_ready      (res_ready),
        .pht            (pht_bus),
        .init_done      (init_done),
        .c_total        (c_total),
        .c_correct      (c_correct)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pht_bus.pht_en && pht_bus.pht_we) begin
            mem[pht_bus.pht_addr] <= pht_bus.pht_wdata;
            last_wr_addr          <= pht_bus.pht_addr;
            last_wr_data          <= pht_bus.pht_wdata;
            wr_count              <= wr_count + 1;
        end
        if (pht_bus.pht_en && !pht_bus.pht_we) begin
            pht_bus.pht_rdata <= mem[pht_bus.pht_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_ENT; k++) ref_ctr[k] = 1;
        exp_total   = 0;
        exp_correct = 0;
    endtask

    task automatic model_accept(input logic [31:0] pc, input logic taken, input logic pred);
        int k;
        k = int'(idx_of(pc));
        if (taken) ref_ctr[k] = (ref_ctr[k] >= 3) ? 3 : ref_ctr[k] + 1;
        else       ref_ctr[k] = (ref_ctr[k] <= 0) ? 0 : ref_ctr[k] - 1;
        exp_total = exp_total + 1;
        if (pred == taken) exp_correct = exp_correct + 1;
    endtask

    task automatic test_reset();
        logic [12:0] got, want;
        rst = 1'b1; lookup_req = 1'b1; lookup_pc = 32'h44;
        res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_prediction = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({pred_valid, init_done, c_total, c_correct} !== 66'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: pv=%0b done=%0b total=%0d correct=%0d required all 0",
                     pred_valid, init_done, c_total, c_correct);
        end
        for (int i = 0; i < N_ENT; i++) begin
            if (i > 0) @(negedge clk);
            got  = {pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr, pht_bus.pht_wdata,
                    res_ready, lookup_grant, pred_valid, init_done};
            want = {1'b1, 1'b1, IDX_W'(i), 2'b01, 4'b0000};
            checks++;
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL sweep_cycle_%0d: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
        lookup_req = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({init_done, c_total} !== {1'b1, 32'd0}) begin
            failures++;
            $display("[TB] FAIL init_done_cycle65: done=%0b total=%0d required 1/0", init_done, c_total);
        end
        step();
    endtask

    task automatic test_single_update();
        res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_prediction = 1'b1;
        @(negedge clk);
        checks++;
        if (res_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_ready: got %0b required 1", res_ready);
        end
        model_accept(res_pc, res_taken, res_prediction);
        step();
        res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr} !== {2'b10, 6'h10}) begin
            failures++;
            $display("[TB] FAIL single_read_n1: en=%0b we=%0b addr=%0h required 1/0/10",
                     pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (pht_bus.pht_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_idle_n2: en=%0b required 0", pht_bus.pht_en);
        end
        step();
        @(negedge clk);
        checks++;
        if ({pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr, pht_bus.pht_wdata} !== {2'b11, 6'h10, 2'b10}) begin
            failures++;
            $display("[TB] FAIL single_write_n3: en=%0b we=%0b addr=%0h data=%0b required 1/1/10/10",
                     pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr, pht_bus.pht_wdata);
        end
        step();
        @(negedge clk);
        checks++;
        if ({c_total, c_correct} !== {32'd1, 32'd1}) begin
            failures++;
            $display("[TB] FAIL single_counts: total=%0d correct=%0d required 1/1", c_total, c_correct);
        end
        step();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_pc = 32'h80; res_taken = 1'b1; res_prediction = (i != 1);
            @(negedge clk);
            checks++;
            if (res_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL sat_ready_%0d: got %0b required 1", i, res_ready);
            end
            model_accept(res_pc, res_taken, res_prediction);
            step();
        end
        res_valid = 1'b0;
        step_n(12);
        @(negedge clk);
        checks++;
        if ({last_wr_addr, last_wr_data, mem[6'h20]} !== {6'h20, 2'b11, 2'(ref_ctr[32'h20])}) begin
            failures++;
            $display("[TB] FAIL sat_three: addr=%0h data=%0b mem=%0b required 20/11/%0d",
                     last_wr_addr, last_wr_data, mem[6'h20], ref_ctr[32'h20]);
        end
        step();
        res_valid = 1'b1; res_pc = 32'h80; res_taken = 1'b1; res_prediction = 1'b1;
        model_accept(res_pc, res_taken, res_prediction);
        step();
        res_valid = 1'b0;
        step_n(6);
        @(negedge clk);
        checks++;
        if ({last_wr_addr, last_wr_data, c_total, c_correct} !==
            {6'h20, 2'b11, 32'(exp_total), 32'(exp_correct)}) begin
            failures++;
            $display("[TB] FAIL sat_fourth: addr=%0h data=%0b total=%0d correct=%0d required 20/11/%0d/%0d",
                     last_wr_addr, last_wr_data, c_total, c_correct, exp_total, exp_correct);
        end
        step();
    endtask

    task automatic test_lookup_stall();
        logic exp_pt;
        logic [IDX_W-1:0] li;
        res_valid = 1'b1; res_pc = 32'h14; res_taken = 1'b0; res_prediction = 1'b0; lookup_req = 1'b0;
        model_accept(res_pc, res_taken, res_prediction);
        step();
        res_valid = 1'b0;
        step_n(2);
        exp_pt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            lookup_req = 1'b1;
            lookup_pc  = (i == 0) ? 32'h14 : $urandom;
            li = idx_of(lookup_pc);
            @(negedge clk);
            checks++;
            if ({lookup_grant, pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr} !== {3'b110, li}) begin
                failures++;
                $display("[TB] FAIL stall_cycle_%0d: grant=%0b en=%0b we=%0b addr=%0h required 1/1/0/%0h",
                         i, lookup_grant, pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr, li);
            end
            if (i > 0) begin
                checks++;
                if ({pred_valid, pred_taken} !== {1'b1, exp_pt}) begin
                    failures++;
                    $display("[TB] FAIL stall_pred_%0d: pv=%0b pt=%0b required 1/%0b",
                             i, pred_valid, pred_taken, exp_pt);
                end
            end
            exp_pt = mem[li][1];
            step();
        end
        lookup_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({lookup_grant, pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr, pht_bus.pht_wdata} !==
            {3'b011, 6'h05, 2'b00}) begin
            failures++;
            $display("[TB] FAIL stall_release_write: grant=%0b en=%0b we=%0b addr=%0h data=%0b required 0/1/1/5/00",
                     lookup_grant, pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr, pht_bus.pht_wdata);
        end
        checks++;
        if ({pred_valid, pred_taken} !== {1'b1, exp_pt}) begin
            failures++;
            $display("[TB] FAIL stall_last_pred: pv=%0b pt=%0b required 1/%0b", pred_valid, pred_taken, exp_pt);
        end
        step_n(4);
    endtask

    task automatic test_full();
        int  accepted;
        logic exp_ready;
        accepted = 0;
        lookup_req = 1'b1; lookup_pc = 32'h0; res_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            res_valid = 1'b1; res_pc = 32'hC0 + 32'(4 * i);
            res_taken = 1'($urandom_range(0, 1)); res_prediction = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_ready = (accepted < DEPTH);
            checks++;
            if (res_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL full_ready_%0d: got %0b required %0b", i, res_ready, exp_ready);
            end
            if (exp_ready) begin
                model_accept(res_pc, res_taken, res_prediction);
                accepted++;
            end
            step();
        end
        res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_ready, c_total} !== {1'b0, 32'(exp_total)}) begin
            failures++;
            $display("[TB] FAIL full_hold: ready=%0b total=%0d required 0/%0d", res_ready, c_total, exp_total);
        end
        step();
        lookup_req = 1'b0;
        step_n(20);
        @(negedge clk);
        checks++;
        if ({res_ready, c_total, c_correct} !== {1'b1, 32'(exp_total), 32'(exp_correct)}) begin
            failures++;
            $display("[TB] FAIL full_drain: ready=%0b total=%0d correct=%0d required 1/%0d/%0d",
                     res_ready, c_total, c_correct, exp_total, exp_correct);
        end
        for (int k = 48; k < 52; k++) begin
            checks++;
            if (mem[k] !== 2'(ref_ctr[k])) begin
                failures++;
                $display("[TB] FAIL full_ctr_%0d: got %0d required %0d", k, mem[k], ref_ctr[k]);
            end
        end
        step();
    endtask

    task automatic test_reset_in_wr();
        logic [31:0] pcs [3];
        int snap;
        bit seen;
        pcs[0] = 32'h0C; pcs[1] = 32'h1C; pcs[2] = 32'h2C;
        lookup_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_pc = pcs[i]; res_taken = 1'b1; res_prediction = 1'b1;
            model_accept(res_pc, res_taken, res_prediction);
            step();
        end
        res_valid = 1'b0; lookup_req = 1'b1; lookup_pc = 32'h0;
        snap = wr_count;
        step_n(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr, pht_bus.pht_wdata, lookup_grant, pred_valid, res_ready}
            !== {2'b11, 6'h00, 2'b01, 3'b000}) begin
            failures++;
            $display("[TB] FAIL rstwr_restart: en=%0b we=%0b addr=%0h data=%0b grant=%0b pv=%0b ready=%0b required 1/1/0/01/0/0/0",
                     pht_bus.pht_en, pht_bus.pht_we, pht_bus.pht_addr, pht_bus.pht_wdata,
                     lookup_grant, pred_valid, res_ready);
        end
        checks++;
        if ({c_total, c_correct} !== 64'd0) begin
            failures++;
            $display("[TB] FAIL rstwr_counts: total=%0d correct=%0d required 0/0", c_total, c_correct);
        end
        checks++;
        if (wr_count !== snap) begin
            failures++;
            $display("[TB] FAIL rstwr_no_write: writes=%0d required 0", wr_count - snap);
        end
        @(posedge clk); #1;
        lookup_req = 1'b0;
        step_n(63);
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pht_bus.pht_en) seen = 1'b1;
            step();
        end
        checks++;
        if ({seen, mem[3], mem[7], mem[11]} !== {1'b0, 6'b010101}) begin
            failures++;
            $display("[TB] FAIL rstwr_queue_discarded: port_used=%0b ctr=%0b/%0b/%0b required 0/01/01/01",
                     seen, mem[3], mem[7], mem[11]);
        end
    endtask

    task automatic test_random();
        logic exp_pv, exp_pt;
        exp_pv = 1'b0; exp_pt = 1'b0;
        for (int c = 0; c < 400; c++) begin
            lookup_req     = 1'($urandom_range(0, 1));
            lookup_pc      = $urandom;
            res_valid      = ($urandom_range(0, 2) == 0);
            res_pc         = $urandom;
            res_taken      = 1'($urandom_range(0, 1));
            res_prediction = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (lookup_grant !== lookup_req) begin
                failures++;
                $display("[TB] FAIL rand_grant_%0d: got %0b required %0b", c, lookup_grant, lookup_req);
            end
            checks++;
            if ({pred_valid, pred_taken} !== {exp_pv, exp_pt}) begin
                failures++;
                $display("[TB] FAIL rand_pred_%0d: pv=%0b pt=%0b required %0b/%0b",
                         c, pred_valid, pred_taken, exp_pv, exp_pt);
            end
            exp_pv = lookup_req;
            exp_pt = lookup_req ? mem[idx_of(lookup_pc)][1] : 1'b0;
            if (res_valid && res_ready) model_accept(res_pc, res_taken, res_prediction);
            step();
        end
        lookup_req = 1'b0; res_valid = 1'b0;
        step_n(30);
        @(negedge clk);
        checks++;
        if ({c_total, c_correct} !== {32'(exp_total), 32'(exp_correct)}) begin
            failures++;
            $display("[TB] FAIL rand_counts: total=%0d correct=%0d required %0d/%0d",
                     c_total, c_correct, exp_total, exp_correct);
        end
        for (int k = 0; k < N_ENT; k++) begin
            checks++;
            if (mem[k] !== 2'(ref_ctr[k])) begin
                failures++;
                $display("[TB] FAIL rand_ctr_%0d: got %0d required %0d", k, mem[k], ref_ctr[k]);
            end
        end
        step();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; lookup_req = 1'b0; lookup_pc = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_prediction = 1'b0;
        #1;
        test_reset();
        test_single_update();
        test_saturate();
        test_lookup_stall();
        test_full();
        test_reset_in_wr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
